// File: rtl/fft64_pkg.sv
// fft64_pkg: shared constants and types for the FFT result capture block.
//   N      points per frame
//   AW     index width (log2 N)
//   DW     width of real / imaginary result words
//   DROPW  width of the dropped-frame counter
package fft64_pkg;

  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DW    = 19;
  localparam int DROPW = 8;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    CAP_WAIT = 2'd0,
    CAP_CAPT = 2'd1,
    CAP_DROP = 2'd2
  } cap_state_e;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Saturating increment for the dropped-frame counter.
  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
    if (v == {DROPW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(DROPW-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/fft64_pingpong_buf.sv
// fft64_pingpong_buf: two N-entry sample banks with per-bank EMPTY/FULL state
// and a per-bank frame-overflow bit.
//   clk_i, rst_i              clock, synchronous active-high reset
//   we_i, wbank_i, waddr_i,
//   wdata_i                   sample write port
//   set_full_i, set_bank_i,
//   set_ovf_i                 mark a bank FULL and store its overflow bit
//   clr_i, clr_bank_i         mark a bank EMPTY (frame fully drained)
//   rbank_i, raddr_i          combinational read address
//   rdata_o, rovf_o           read sample and overflow bit of the read bank
//   full_o                    FULL flag of each bank
module fft64_pingpong_buf
  import fft64_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  sample_t       wdata_i,
  input  logic          set_full_i,
  input  logic          set_bank_i,
  input  logic          set_ovf_i,
  input  logic          clr_i,
  input  logic          clr_bank_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output sample_t       rdata_o,
  output logic          rovf_o,
  output logic [1:0]    full_o
);

  sample_t     mem_q   [2][N];
  bank_state_e state_q [2];
  logic        ovf_q   [2];

  // Sample storage; contents are only consumed while the bank is FULL, so no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  // Bank state and overflow flags. Fill and drain never target the same bank
  // in one cycle, since a bank being captured is never FULL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      ovf_q[0]   <= 1'b0;
      ovf_q[1]   <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (set_full_i && (set_bank_i == 1'(b))) begin
          state_q[b] <= BANK_FULL;
          ovf_q[b]   <= set_ovf_i;
        end else if (clr_i && (clr_bank_i == 1'(b))) begin
          state_q[b] <= BANK_EMPTY;
        end
      end
    end
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];
  assign rovf_o  = ovf_q[rbank_i];
  assign full_o  = {state_q[1] == BANK_FULL, state_q[0] == BANK_FULL};

endmodule

// File: rtl/fft64_result_capture.sv
// fft64_result_capture: captures 64-point FFT result frames (ED-qualified,
// addressed by ADDR) into a ping-pong buffer and replays each frame in index
// order on a valid/ready stream.
//   CLK, RST                      clock, synchronous active-high reset
//   ED, RDY, ADDR, DOR, DOI,
//   OVF1, OVF2                    FFT core result interface
//   OUT_VALID, OUT_READY          stream handshake
//   OUT_RE, OUT_IM, OUT_IDX,
//   OUT_LAST, OUT_OVF             stream sample fields
//   SEQ_ERR                       one-cycle pulse on a sequencing error
//   DROP_CNT                      saturating dropped-frame count
module fft64_result_capture
  import fft64_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             ED,
  input  logic             RDY,
  input  logic [AW-1:0]    ADDR,
  input  logic [DW-1:0]    DOR,
  input  logic [DW-1:0]    DOI,
  input  logic             OVF1,
  input  logic             OVF2,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [DW-1:0]    OUT_RE,
  output logic [DW-1:0]    OUT_IM,
  output logic [AW-1:0]    OUT_IDX,
  output logic             OUT_LAST,
  output logic             OUT_OVF,
  output logic             SEQ_ERR,
  output logic [DROPW-1:0] DROP_CNT
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Capture side state
  cap_state_e       state_q, state_d;
  logic             wbank_q, wbank_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [DROPW-1:0] drop_q, drop_d;
  logic             seq_err_q, seq_err_d;

  // Drain side state
  logic             rbank_q, rbank_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_re_q, out_re_d;
  logic [DW-1:0]    out_im_q, out_im_d;
  logic [AW-1:0]    out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_ovf_q, out_ovf_d;

  // Buffer interface
  logic             we_s;
  logic             set_full_s;
  logic             set_ovf_s;
  logic             free_s;
  logic             load_s;
  logic             rd_bank_s;
  logic [AW-1:0]    rd_addr_s;
  sample_t          wdata_s;
  sample_t          rdata_s;
  logic             rovf_s;
  logic [1:0]       full_s;

  logic             ovf_in_s;
  logic             xfer_s;
  logic             restart_s;
  logic             wbank_avail_s;

  assign ovf_in_s  = OVF1 | OVF2;
  assign wdata_s   = '{re: DOR, im: DOI};
  assign set_ovf_s = ovf_q | ovf_in_s;
  assign xfer_s    = out_valid_q & OUT_READY;
  assign free_s    = xfer_s & out_last_q;
  // A bank released by this cycle's last transfer already counts as empty.
  assign wbank_avail_s = ~full_s[wbank_q] | (free_s & (rbank_q == wbank_q));
  // RDY inside a frame restarts it; on the final sample it is just completion.
  assign restart_s = (state_q == CAP_CAPT) & ED & RDY & (cnt_q != LAST_IDX);

  fft64_pingpong_buf u_buf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .we_i       (we_s),
    .wbank_i    (wbank_q),
    .waddr_i    (ADDR),
    .wdata_i    (wdata_s),
    .set_full_i (set_full_s),
    .set_bank_i (wbank_q),
    .set_ovf_i  (set_ovf_s),
    .clr_i      (free_s),
    .clr_bank_i (rbank_q),
    .rbank_i    (rd_bank_s),
    .raddr_i    (rd_addr_s),
    .rdata_o    (rdata_s),
    .rovf_o     (rovf_s),
    .full_o     (full_s)
  );

  // Capture FSM state and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CAP_WAIT;
      wbank_q   <= 1'b0;
      cnt_q     <= IDX_ZERO;
      ovf_q     <= 1'b0;
      drop_q    <= {DROPW{1'b0}};
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wbank_q   <= wbank_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Capture FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_WAIT: begin
        if (ED && RDY) begin
          state_d = wbank_avail_s ? CAP_CAPT : CAP_DROP;
        end else begin
          state_d = CAP_WAIT;
        end
      end
      CAP_CAPT: begin
        if (ED && !restart_s && (cnt_q == LAST_IDX)) begin
          state_d = CAP_WAIT;
        end else begin
          state_d = CAP_CAPT;
        end
      end
      CAP_DROP: begin
        if (ED && (cnt_q == LAST_IDX)) begin
          state_d = CAP_WAIT;
        end else begin
          state_d = CAP_DROP;
        end
      end
      default: begin
        state_d = CAP_WAIT;
      end
    endcase
  end

  // Capture FSM outputs: buffer writes, counters, overflow accumulation, errors
  always_comb begin
    we_s       = 1'b0;
    set_full_s = 1'b0;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    wbank_d    = wbank_q;
    drop_d     = drop_q;
    seq_err_d  = 1'b0;
    case (state_q)
      CAP_WAIT: begin
        if (ED && RDY) begin
          cnt_d = IDX_ONE;
          if (wbank_avail_s) begin
            we_s  = 1'b1;
            ovf_d = ovf_in_s;
          end else begin
            drop_d = sat_inc(drop_q);
          end
        end else begin
          cnt_d = IDX_ZERO;
        end
      end
      CAP_CAPT: begin
        if (ED) begin
          we_s = 1'b1;
          if (restart_s) begin
            cnt_d     = IDX_ONE;
            ovf_d     = ovf_in_s;
            seq_err_d = 1'b1;
          end else begin
            seq_err_d = (ADDR != cnt_q);
            ovf_d     = ovf_q | ovf_in_s;
            if (cnt_q == LAST_IDX) begin
              set_full_s = 1'b1;
              wbank_d    = ~wbank_q;
              cnt_d      = IDX_ZERO;
            end else begin
              cnt_d = cnt_q + IDX_ONE;
            end
          end
        end else begin
          we_s = 1'b0;
        end
      end
      CAP_DROP: begin
        if (ED) begin
          cnt_d = (cnt_q == LAST_IDX) ? IDX_ZERO : (cnt_q + IDX_ONE);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = IDX_ZERO;
      end
    endcase
  end

  // Drain control: pick what the output register presents next cycle
  always_comb begin
    rbank_d     = rbank_q;
    out_valid_d = out_valid_q;
    rd_bank_s   = rbank_q;
    rd_addr_s   = out_idx_q;
    load_s      = 1'b0;
    if (xfer_s && out_last_q) begin
      // Frame done: release the bank and continue from the other one if ready.
      rbank_d   = ~rbank_q;
      rd_bank_s = ~rbank_q;
      rd_addr_s = IDX_ZERO;
      if (full_s[~rbank_q]) begin
        load_s = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (xfer_s) begin
      rd_addr_s = out_idx_q + IDX_ONE;
      load_s    = 1'b1;
    end else if (!out_valid_q && full_s[rbank_q]) begin
      rd_addr_s = IDX_ZERO;
      load_s    = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    if (load_s) begin
      out_valid_d = 1'b1;
    end else begin
      rd_bank_s = rd_bank_s;
    end
  end

  assign out_re_d   = load_s ? rdata_s.re : out_re_q;
  assign out_im_d   = load_s ? rdata_s.im : out_im_q;
  assign out_idx_d  = load_s ? rd_addr_s : out_idx_q;
  assign out_last_d = load_s ? (rd_addr_s == LAST_IDX) : out_last_q;
  assign out_ovf_d  = load_s ? rovf_s : out_ovf_q;

  // Stream output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      rbank_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= {DW{1'b0}};
      out_im_q    <= {DW{1'b0}};
      out_idx_q   <= IDX_ZERO;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      rbank_q     <= rbank_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_RE    = out_re_q;
  assign OUT_IM    = out_im_q;
  assign OUT_IDX   = out_idx_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_OVF   = out_ovf_q;
  assign SEQ_ERR   = seq_err_q;
  assign DROP_CNT  = drop_q;

endmodule
